bin2bcd_converter3: RTL and testbench

BIN2BCD_CONVERTER3 -- requirements
Module: bin2bcd_converter3

---
 rtl/bin2bcd_converter3.sv | 78 +++++++
 tb/tb_bin2bcd_converter3.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_converter3.sv
// Registered binary-to-BCD converter: lower three decimal digits of Input, 1-cycle latency.
// Optional macro BIN2BCD3_SATURATE_EN: values above 999 saturate to 999 and raise Overflow.
module bin2bcd_converter3 #(
    parameter int unsigned INPUT_BIT_WIDTH = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [INPUT_BIT_WIDTH-1:0] Input,
    input  logic                       InValid,
    output logic [0:3]                 Digit2,
    output logic [0:3]                 Digit1,
    output logic [0:3]                 Digit0,
    output logic                       OutValid
`ifdef BIN2BCD3_SATURATE_EN
    ,
    output logic                       Overflow
`endif
);

    localparam int unsigned W        = INPUT_BIT_WIDTH;
    // floor(W*log10(2)) + 1 decimal digits cover 2^W-1; keep at least four so the
    // digits above hundreds always exist as a slice.
    localparam int unsigned NDIG_MIN = (W * 301) / 1000 + 1;
    localparam int unsigned NDIG     = (NDIG_MIN < 4) ? 4 : NDIG_MIN;
    localparam int unsigned BW       = 4 * NDIG;

    logic [BW-1:0] bcd;
    logic [11:0]   low;

    // Shift-add-3 over every input bit, MSB first.
    always_comb begin
        bcd = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            for (int d = 0; d < int'(NDIG); d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[BW-2:0], Input[i]};
        end
    end

`ifdef BIN2BCD3_SATURATE_EN
    logic over;

    // Any nonzero thousands-or-above digit means the value exceeds 999.
    assign over = |bcd[BW-1:12];
    assign low  = over ? 12'h999 : bcd[11:0];
`else
    logic unused_hi;

    assign unused_hi = ^bcd[BW-1:12];
    assign low       = bcd[11:0];
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Digit2   <= 4'd0;
            Digit1   <= 4'd0;
            Digit0   <= 4'd0;
            OutValid <= 1'b0;
`ifdef BIN2BCD3_SATURATE_EN
            Overflow <= 1'b0;
`endif
        end else begin
            OutValid <= InValid;
            if (InValid) begin
                Digit2   <= low[11:8];
                Digit1   <= low[7:4];
                Digit0   <= low[3:0];
`ifdef BIN2BCD3_SATURATE_EN
                Overflow <= over;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_converter3.sv
// Self-checking bench for bin2bcd_converter3: directed vector table, exhaustive 0..999, random vs arithmetic model.
module tb_bin2bcd_converter3;

    localparam int unsigned W = 16;
`ifdef BIN2BCD3_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] Input;
    logic         InValid;
    logic [0:3]   Digit2, Digit1, Digit0;
    logic         OutValid;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_converter3 #(.INPUT_BIT_WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Input    (Input),
        .InValid  (InValid),
        .Digit2   (Digit2),
        .Digit1   (Digit1),
        .Digit0   (Digit0),
`ifdef BIN2BCD3_SATURATE_EN
        .Overflow (ovf),
`endif
        .OutValid (OutValid)
    );

`ifndef BIN2BCD3_SATURATE_EN
    assign ovf = 1'b0;
`endif

    always #5 Clock = ~Clock;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] val;
        int           e2;
        int           e1;
        int           e0;
        logic         ev;
        logic         eo;
    } vec_t;

    vec_t tbl[$];

    // Model state: what the outputs should show after the next edge.
    int   m_num = 0;
    logic m_vld = 1'b0;
    logic m_ovf = 1'b0;

    function automatic vec_t mk(logic rst, logic vld, int val, int e2, int e1, int e0, logic ev, logic eo);
        vec_t v;
        v.rst = rst; v.vld = vld; v.val = W'(val);
        v.e2 = e2; v.e1 = e1; v.e0 = e0; v.ev = ev; v.eo = eo;
        return v;
    endfunction

    task automatic step(input logic rst, input logic vld, input logic [W-1:0] val);
        Reset   = rst;
        InValid = vld;
        Input   = val;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input int e2, input int e1, input int e0,
                         input logic ev, input logic eo);
        logic [3:0] g2, g1, g0;
        g2 = Digit2; g1 = Digit1; g0 = Digit0;
        n_cmp++;
        if (int'(g2) != e2 || int'(g1) != e1 || int'(g0) != e0 || OutValid !== ev || ovf !== eo) begin
            n_bad++;
            $display("FAIL %s: got %0d/%0d/%0d valid=%b ovf=%b, want %0d/%0d/%0d valid=%b ovf=%b",
                     name, g2, g1, g0, OutValid, ovf, e2, e1, e0, ev, eo);
        end
    endtask

    // Arithmetic reference: value mod 1000, or clamped to 999 when saturating.
    task automatic model(input logic rst, input logic vld, input logic [W-1:0] val);
        int v;
        v = int'(val);
        if (!rst) begin
            m_num = 0; m_vld = 1'b0; m_ovf = 1'b0;
        end else begin
            m_vld = vld;
            if (vld) begin
                m_ovf = SAT && (v > 999);
                m_num = m_ovf ? 999 : (v % 1000);
            end
        end
    endtask

    initial begin
        Reset = 1'b0; InValid = 1'b0; Input = '0;

        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0,     0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 10,    0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 142,   1, 4, 2, 1, 0));
        tbl.push_back(mk(1, 1, 89,    0, 8, 9, 1, 0));
        tbl.push_back(mk(1, 1, 33,    0, 3, 3, 1, 0));
        tbl.push_back(mk(1, 1, 599,   5, 9, 9, 1, 0));
        tbl.push_back(mk(1, 1, 999,   9, 9, 9, 1, 0));
        tbl.push_back(mk(1, 1, 1000,  SAT ? 9 : 0, SAT ? 9 : 0, SAT ? 9 : 0, 1, SAT));
        tbl.push_back(mk(1, 1, 65535, SAT ? 9 : 5, SAT ? 9 : 3, SAT ? 9 : 5, 1, SAT));
        tbl.push_back(mk(1, 1, 142,   1, 4, 2, 1, 0));
        tbl.push_back(mk(1, 0, 7,     1, 4, 2, 0, 0));
        tbl.push_back(mk(1, 0, 7,     1, 4, 2, 0, 0));
        tbl.push_back(mk(0, 1, 599,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7,     0, 0, 7, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].val);
            check($sformatf("vec%0d_in%0d", i, tbl[i].val),
                  tbl[i].e2, tbl[i].e1, tbl[i].e0, tbl[i].ev, tbl[i].eo);
        end

        // Exhaustive back-to-back sweep of the exact range.
        for (int v = 0; v <= 999; v++) begin
            step(1'b1, 1'b1, W'(v));
            check($sformatf("sweep%0d", v), v / 100, (v / 10) % 10, v % 10, 1'b1, 1'b0);
        end

        // Random traffic against the model, starting from a reset.
        step(1'b0, 1'b0, '0);
        model(1'b0, 1'b0, '0);
        check("rand_reset", 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            logic         r, vl;
            logic [W-1:0] x;
            r  = ($urandom % 40) != 0;
            vl = ($urandom % 4) != 0;
            x  = (($urandom % 2) != 0) ? W'($urandom % 1200) : W'($urandom);
            step(r, vl, x);
            model(r, vl, x);
            check($sformatf("rand%0d_in%0d", k, x),
                  m_num / 100, (m_num / 10) % 10, m_num % 10, m_vld, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
